// File: rtl/m_clk_gate_pkg.sv
// m_clk_gate_pkg: shared types and helpers for the gated-clock scheduler.
// Holds the FSM state encoding and the settle/idle counter sizing function.
package m_clk_gate_pkg;

  typedef enum logic [1:0] {
    OFF  = 2'd0,
    WAKE = 2'd1,
    ON   = 2'd2,
    HOLD = 2'd3
  } gate_state_e;

  function automatic int cnt_width(
    input int wake_cyc,
    input int idle_cyc
  );
    int m;
    m = 1;
    if (wake_cyc > m) m = wake_cyc;
    if (idle_cyc > m) m = idle_cyc;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/m_load_down_cnt.sv
// m_load_down_cnt: loadable down-counter with a zero flag.
// Load beats decrement; decrement stops at zero.
module m_load_down_cnt
  import m_clk_gate_pkg::*;
#(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         zero
);

  assign zero = (cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && !zero) begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/m_clk_gate_ctrl.sv
// m_clk_gate_ctrl: wake-settle / idle-hysteresis scheduler for one gated domain.
// Optional gated-cycle statistics counter under CLK_GATE_STATS_EN.
module m_clk_gate_ctrl
  import m_clk_gate_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int WAKE_CYC = 2,
  parameter int IDLE_CYC = 8,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             force_on,
  output logic [N_REQ-1:0] ack,
  output logic             clk_en,
  output logic             busy
`ifdef CLK_GATE_STATS_EN
  ,
  output logic [CNT_W-1:0] gated_cnt
`endif
);

  localparam int CW = cnt_width(WAKE_CYC, IDLE_CYC);
  localparam logic [CW-1:0] W_INIT = CW'(WAKE_CYC - 1);
  localparam logic [CW-1:0] I_INIT =
    CW'((IDLE_CYC > 0) ? IDLE_CYC - 1 : 0);

  gate_state_e state_q, state_d;
  logic        en_q;
  logic        demand;
  logic        w_load, w_dec, w_zero;
  logic        i_load, i_dec, i_zero;
  logic [CW-1:0] wcnt, icnt;

  if (N_REQ < 1 || WAKE_CYC < 1 || IDLE_CYC < 0 || CNT_W < 1)
  begin : g_cfg_invalid
  end

  assign demand = (|req) | force_on;

  m_load_down_cnt #(.W(CW)) u_wcnt (
    .clk      (clk),
    .rst      (rst),
    .load     (w_load),
    .load_val (W_INIT),
    .dec      (w_dec),
    .cnt      (wcnt),
    .zero     (w_zero)
  );

  m_load_down_cnt #(.W(CW)) u_icnt (
    .clk      (clk),
    .rst      (rst),
    .load     (i_load),
    .load_val (I_INIT),
    .dec      (i_dec),
    .cnt      (icnt),
    .zero     (i_zero)
  );

  always_comb begin
    state_d = state_q;
    w_load  = 1'b0;
    w_dec   = 1'b0;
    i_load  = 1'b0;
    i_dec   = 1'b0;
    unique case (state_q)
      OFF: begin
        if (demand) begin
          state_d = WAKE;
          w_load  = 1'b1;
        end
      end
      WAKE: begin
        // settle always completes, even if demand went away
        if (w_zero) state_d = ON;
        else        w_dec   = 1'b1;
      end
      ON: begin
        if (!demand) begin
          if (IDLE_CYC == 0) begin
            state_d = OFF;
          end else begin
            state_d = HOLD;
            i_load  = 1'b1;
          end
        end
      end
      HOLD: begin
        if (demand)      state_d = ON;
        else if (i_zero) state_d = OFF;
        else             i_dec   = 1'b1;
      end
      default: state_d = OFF;
    endcase
  end

  // dedicated enable flop so the gate cell never sees a decode glitch
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= OFF;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      en_q    <= (state_d != OFF);
    end
  end

  assign clk_en = en_q;
  assign busy   = en_q;
  assign ack    = req & {N_REQ{state_q == ON}};

`ifdef CLK_GATE_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      gated_cnt <= '0;
    end else if (!en_q && (gated_cnt != '1)) begin
      gated_cnt <= gated_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_m_clk_gate_ctrl.sv
// tb_m_clk_gate_ctrl: scoreboard bench for the gated-clock scheduler.
// Per-cycle expectations come from the wake/idle latency rules.
module tb_m_clk_gate_ctrl;

  localparam int N_REQ    = 4;
  localparam int WAKE_CYC = 2;
  localparam int IDLE_CYC = 4;

  typedef struct packed {
    logic [N_REQ-1:0] ack;
    logic             en;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [N_REQ-1:0] req = '1;
  logic             force_on = 1'b1;
  logic [N_REQ-1:0] ack;
  logic             clk_en;
  logic             busy;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

`ifdef CLK_GATE_STATS_EN
  logic [15:0] gated_cnt;
  logic [N_REQ-1:0] ack_s;
  logic clk_en_s, busy_s;
  logic [3:0] gated_cnt_s;
`endif

  m_clk_gate_ctrl #(
    .N_REQ    (N_REQ),
    .WAKE_CYC (WAKE_CYC),
    .IDLE_CYC (IDLE_CYC),
    .CNT_W    (16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .force_on (force_on),
    .ack      (ack),
    .clk_en   (clk_en),
    .busy     (busy)
`ifdef CLK_GATE_STATS_EN
    ,
    .gated_cnt(gated_cnt)
`endif
  );

`ifdef CLK_GATE_STATS_EN
  m_clk_gate_ctrl #(
    .N_REQ    (N_REQ),
    .WAKE_CYC (WAKE_CYC),
    .IDLE_CYC (IDLE_CYC),
    .CNT_W    (4)
  ) dut_sat (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .force_on (force_on),
    .ack      (ack_s),
    .clk_en   (clk_en_s),
    .busy     (busy_s),
    .gated_cnt(gated_cnt_s)
  );
`endif

  task automatic cyc(
    input logic [N_REQ-1:0] r,
    input logic             f,
    input logic             rs
  );
    @(posedge clk);
    #1;
    req      = r;
    force_on = f;
    rst      = rs;
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    for (int c = 0; c < 5; c++) begin
      if (c < 3) cyc('1, 1'b1, 1'b1);
      else       cyc('0, 1'b0, 1'b0);
      sb.push_back(exp_t'{ack: '0, en: 1'b0});
      e = sb.pop_front();
      checks++;
      if (clk_en !== e.en) begin
        errors++;
        $display("FAIL reset c=%0d clk_en=%b exp=%b", c, clk_en, e.en);
      end
      checks++;
      if (busy !== e.en) begin
        errors++;
        $display("FAIL reset c=%0d busy=%b exp=%b", c, busy, e.en);
      end
      checks++;
      if (ack !== e.ack) begin
        errors++;
        $display("FAIL reset c=%0d ack=%b exp=%b", c, ack, e.ack);
      end
    end
  endtask

  task automatic test_wake_gateoff();
    exp_t e;
    logic [N_REQ-1:0] r;
    for (int c = 0; c < 20; c++) begin
      r = (c < 10) ? 4'b0001 : 4'b0000;
      cyc(r, 1'b0, 1'b0);
      sb.push_back(exp_t'{
        ack: (c >= 1 + WAKE_CYC && c < 10) ? 4'b0001 : 4'b0000,
        en:  (c >= 1 && c < 11 + IDLE_CYC)});
      e = sb.pop_front();
      checks++;
      if (clk_en !== e.en || busy !== e.en) begin
        errors++;
        $display("FAIL wake c=%0d clk_en=%b busy=%b exp=%b",
                 c, clk_en, busy, e.en);
      end
      checks++;
      if (ack !== e.ack) begin
        errors++;
        $display("FAIL wake c=%0d ack=%b exp=%b", c, ack, e.ack);
      end
    end
  endtask

  task automatic test_rereq_hold();
    exp_t e;
    logic [N_REQ-1:0] r;
    logic [N_REQ-1:0] a;
    for (int c = 0; c < 26; c++) begin
      r = (c < 10) ? 4'b0001 :
          (c >= 13 && c < 17) ? 4'b0100 : 4'b0000;
      a = (c >= 1 + WAKE_CYC && c < 10) ? 4'b0001 :
          (c >= 14 && c < 17) ? 4'b0100 : 4'b0000;
      cyc(r, 1'b0, 1'b0);
      sb.push_back(exp_t'{ack: a, en: (c >= 1 && c < 18 + IDLE_CYC)});
      e = sb.pop_front();
      checks++;
      if (clk_en !== e.en || busy !== e.en) begin
        errors++;
        $display("FAIL rereq c=%0d clk_en=%b busy=%b exp=%b",
                 c, clk_en, busy, e.en);
      end
      checks++;
      if (ack !== e.ack) begin
        errors++;
        $display("FAIL rereq c=%0d ack=%b exp=%b", c, ack, e.ack);
      end
    end
  endtask

  task automatic test_hold_boundary();
    exp_t e;
    logic [N_REQ-1:0] r;
    logic [N_REQ-1:0] a;
    int b;
    b = 10 + IDLE_CYC;
    for (int c = 0; c < 26; c++) begin
      r = (c < 10) ? 4'b0001 :
          (c >= b && c < b + 3) ? 4'b0010 : 4'b0000;
      a = (c >= 1 + WAKE_CYC && c < 10) ? 4'b0001 :
          (c >= b + 1 && c < b + 3) ? 4'b0010 : 4'b0000;
      cyc(r, 1'b0, 1'b0);
      sb.push_back(exp_t'{ack: a, en: (c >= 1 && c < b + 4 + IDLE_CYC)});
      e = sb.pop_front();
      checks++;
      if (clk_en !== e.en || busy !== e.en) begin
        errors++;
        $display("FAIL boundary c=%0d clk_en=%b busy=%b exp=%b",
                 c, clk_en, busy, e.en);
      end
      checks++;
      if (ack !== e.ack) begin
        errors++;
        $display("FAIL boundary c=%0d ack=%b exp=%b", c, ack, e.ack);
      end
    end
  endtask

  task automatic test_abandoned_wake();
    exp_t e;
    for (int c = 0; c < 12; c++) begin
      cyc((c == 0) ? 4'b0001 : 4'b0000, 1'b0, 1'b0);
      sb.push_back(exp_t'{
        ack: '0, en: (c >= 1 && c < 2 + WAKE_CYC + IDLE_CYC)});
      e = sb.pop_front();
      checks++;
      if (clk_en !== e.en || busy !== e.en) begin
        errors++;
        $display("FAIL abandon c=%0d clk_en=%b busy=%b exp=%b",
                 c, clk_en, busy, e.en);
      end
      checks++;
      if (ack !== e.ack) begin
        errors++;
        $display("FAIL abandon c=%0d ack=%b exp=%b", c, ack, e.ack);
      end
    end
  endtask

  task automatic test_force_on();
    exp_t e;
    logic [N_REQ-1:0] r;
    for (int c = 0; c < 18; c++) begin
      r = (c >= 6 && c < 8) ? 4'b1000 : 4'b0000;
      cyc(r, (c < 10), 1'b0);
      sb.push_back(exp_t'{ack: r, en: (c >= 1 && c < 11 + IDLE_CYC)});
      e = sb.pop_front();
      checks++;
      if (clk_en !== e.en || busy !== e.en) begin
        errors++;
        $display("FAIL force c=%0d clk_en=%b busy=%b exp=%b",
                 c, clk_en, busy, e.en);
      end
      checks++;
      if (ack !== e.ack) begin
        errors++;
        $display("FAIL force c=%0d ack=%b exp=%b", c, ack, e.ack);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic [N_REQ-1:0] r;
    logic [N_REQ-1:0] a;
    for (int c = 0; c < 16; c++) begin
      r = (c < 5) ? 4'b0011 : (c < 8) ? 4'b1001 : 4'b0000;
      a = (c >= 1 + WAKE_CYC && c < 8) ? r : 4'b0000;
      cyc(r, 1'b0, 1'b0);
      sb.push_back(exp_t'{ack: a, en: (c >= 1 && c < 9 + IDLE_CYC)});
      e = sb.pop_front();
      checks++;
      if (clk_en !== e.en || busy !== e.en) begin
        errors++;
        $display("FAIL b2b c=%0d clk_en=%b busy=%b exp=%b",
                 c, clk_en, busy, e.en);
      end
      checks++;
      if (ack !== e.ack) begin
        errors++;
        $display("FAIL b2b c=%0d ack=%b exp=%b", c, ack, e.ack);
      end
    end
  endtask

  task automatic test_reset_mid_on();
    exp_t e;
    logic [N_REQ-1:0] r;
    logic [N_REQ-1:0] a;
    for (int c = 0; c < 20; c++) begin
      r = (c < 12) ? 4'b0001 : 4'b0000;
      a = ((c >= 1 + WAKE_CYC && c < 6) ||
           (c >= 7 + WAKE_CYC && c < 12)) ? 4'b0001 : 4'b0000;
      cyc(r, 1'b0, (c == 5));
      sb.push_back(exp_t'{
        ack: a,
        en:  ((c >= 1 && c < 6) || (c >= 7 && c < 13 + IDLE_CYC))});
      e = sb.pop_front();
      checks++;
      if (clk_en !== e.en || busy !== e.en) begin
        errors++;
        $display("FAIL rst_mid c=%0d clk_en=%b busy=%b exp=%b",
                 c, clk_en, busy, e.en);
      end
      checks++;
      if (ack !== e.ack) begin
        errors++;
        $display("FAIL rst_mid c=%0d ack=%b exp=%b", c, ack, e.ack);
      end
    end
  endtask

`ifdef CLK_GATE_STATS_EN
  task automatic test_stats();
    cyc('0, 1'b0, 1'b1);
    for (int i = 0; i < 100; i++) cyc('0, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    checks++;
    if (gated_cnt !== 16'd100) begin
      errors++;
      $display("FAIL stats gated_cnt=%0d exp=100", gated_cnt);
    end
    checks++;
    if (gated_cnt_s !== 4'd15) begin
      errors++;
      $display("FAIL stats_sat gated_cnt=%0d exp=15", gated_cnt_s);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_wake_gateoff();
    test_rereq_hold();
    test_hold_boundary();
    test_abandoned_wake();
    test_force_on();
    test_back_to_back();
    test_reset_mid_on();
`ifdef CLK_GATE_STATS_EN
    test_stats();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/m_clk_gate_ctrl.md
Name: m_clk_gate_ctrl

Overview:
- Clock-gating scheduler for a shared gated clock domain built from the std-cell clock gate wrappers (m_nor / clock-gate cells).
- Collects run requests from N_REQ requesters and produces a glitch-safe registered enable, clk_en, for the gate cell.
- Enforces a wake-up settle delay before granting (ack), and an idle hysteresis before gating the clock off again.
- Sits in the clock/reset block beside the std-cell wrappers, one instance per gated domain.

Parameters:
- N_REQ, 4, number of requesters (>=1).
- WAKE_CYC, 2, cycles clk_en is high before the first ack (>=1).
- IDLE_CYC, 8, hysteresis cycles with no demand before gating off (0 = gate off immediately).
- CNT_W, 16, width of the gated-cycle statistics counter.

Ports:
- clk  in  1  free-running clock.
- rst  in  1  synchronous reset, active-high.
- req  in  N_REQ  per-requester run request, level.
- force_on  in  1  software/debug force; counts as demand, never acked.
- ack  out  N_REQ  per-requester grant: the gated clock is running and stable.
- clk_en  out  1  registered enable to the clock-gate cell.
- busy  out  1  high when state != OFF.
- gated_cnt  out  CNT_W  cycles with clk_en==0 (present only with CLK_GATE_STATS_EN).

Behaviour:
- One clock, synchronous active-high reset. rst dominates all other inputs.
- Reset values: state=OFF, clk_en=0, ack=0, busy=0, counters=0, gated_cnt=0.
- demand = |req | force_on.
- States: OFF, WAKE, ON, HOLD. State and counters are registered.
- clk_en = (state != OFF), taken from the state register. No combinational path from req to clk_en.
- ack[i] = req[i] & (state==ON). ack is zero in all other states.
- OFF: if demand, go to WAKE and load wcnt=WAKE_CYC-1.
- WAKE: when wcnt==0, go to ON; otherwise decrement wcnt. WAKE is never aborted: if demand drops, it still completes to ON, then goes to HOLD.
- ON: if !demand, load icnt=IDLE_CYC-1 and go to HOLD; if IDLE_CYC==0, go straight to OFF.
- HOLD: if demand, go to ON (ack is visible the next cycle). Else if icnt==0, go to OFF. Else decrement icnt.
- Simultaneous demand and icnt==0 in HOLD: demand wins, state goes to ON.
- Latency: req rises in cycle t while in OFF:
  - clk_en=1 in cycle t+1;
  - ack=1 in cycle t+1+WAKE_CYC.
- Latency from last demand drop in ON at cycle t to clk_en=0: cycle t+1+IDLE_CYC.
- force_on alone holds state in ON with ack=0.
- Requesters may drop req at any time; ack follows combinationally.
- Reset mid-operation: state=OFF and clk_en=0 in the next cycle. Pending requesters restart from OFF once rst is released.

Optional Feature:
- Macro: CLK_GATE_STATS_EN.
- Defined: gated_cnt port exists. It increments each cycle clk_en==0, saturates at all-ones (no wrap), and is cleared only by rst.
- Undefined: no gated_cnt port and no counter logic; all other behaviour is identical.

Decomposition:
- Package m_clk_gate_pkg holds:
  - the state enum (OFF, WAKE, ON, HOLD), 2-bit;
  - a counter-width function clog2-based, max(WAKE_CYC, IDLE_CYC, 1).
- One sub-module, m_load_down_cnt: a loadable down-counter with a zero flag, instanced for wcnt and icnt.

Test Plan (WAKE_CYC=2, IDLE_CYC=4):
- Wake-up: req=4'b0001 rises at cycle 10 -> clk_en=1 at cycle 11, ack=4'b0001 at cycle 13, busy=1 from cycle 11.
- Gate-off: req drops at cycle 20 -> ack=0 at cycle 20, state HOLD; clk_en=0 at cycle 25, busy=0 at cycle 25.
- Re-request in HOLD: req=4'b0100 at cycle 23 -> ON at cycle 24, ack=4'b0100 at cycle 24, clk_en never drops.
- Contention on the HOLD boundary: req rises in the exact cycle icnt==0 -> state ON, clk_en stays 1.
- Abandoned wake: req pulses 1 cycle in OFF -> WAKE completes, ON for 1 cycle, HOLD, clk_en low after 4 idle cycles; ack stays 0 throughout.
- Reset mid-ON: rst asserted for 1 cycle -> clk_en=0 and ack=0 the next cycle; with req still high, clk_en=1 again 1 cycle after rst is released.
- With CLK_GATE_STATS_EN: 100 idle cycles after reset -> gated_cnt=100; with CNT_W=4, gated_cnt saturates at 15.
